mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the CPU execute stage.
- Radix-2 engine: one product bit or quotient bit per cycle, instead of a single-cycle operator behind a fixed delay counter.
- Adds a start handshake, a done pulse, pipeline flush/cancel, divide-by-zero flagging and signed multiply-accumulate (MADD).
- The stall logic watches busy; mfhi/mflo read hi/lo directly.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO; must be at least 4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request; sampled on a rising edge only while busy=0.
- op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
- srcA  input  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- srcB  input  WIDTH  multiplier or divisor.
- flush  input  1  cancels the operation in flight; HI/LO keep their pre-operation values.
- busy  output  1  engine occupied; the CPU must stall any later MDU instruction or mfhi/mflo.
- done  output  1  one-cycle pulse after HI/LO commit.
- dz  output  1  valid with done; 1 when the committed operation was a DIV/DIVU with srcB=0.
- high  output  WIDTH  committed HI.
- low  output  WIDTH  committed LO.

Behaviour:
- Reset (reset=0, asynchronous): high=0, low=0, busy=0, done=0, dz=0, FSM=IDLE, iteration counter=0.
- The FSM has four states: IDLE, MUL, DIV, COMMIT.
- IDLE, start=1 and op in {1,2,3,4,7} at edge E0:
  - latch the operands;
  - convert them to magnitudes for signed ops (MULT, DIV, MADD);
  - record the result signs;
  - go to MUL (ops 1, 2, 7) or DIV (ops 3, 4).
- IDLE, start=1 and op=5/6: high/low <= srcA at that edge; no busy; no done.
- IDLE, start=1 and op=0: ignored.
- start while busy=1 is ignored; the requester must hold the instruction until busy=0.
- MUL: shift-add, one multiplier bit per edge, for WIDTH edges (E1..E_WIDTH), then COMMIT.
- DIV: restoring division, one quotient bit per edge, for WIDTH edges, then COMMIT.
- COMMIT, edge E_(WIDTH+1):
  - apply sign correction;
  - write high/low;
  - return to IDLE.
- busy=1 from after E0 through E_(WIDTH+1), i.e. WIDTH+1 cycles.
- done=1 for the single cycle following E_(WIDTH+1). A new start is accepted in that same cycle.
- Sign rules:
  - product sign = sign(A) XOR sign(B);
  - quotient sign = sign(A) XOR sign(B);
  - remainder sign = sign(A).
  - The results are the 2WIDTH-bit and WIDTH-bit two's-complement values.
- MULTU/MULT: {high,low} <= product.
- MADD: {high,low} <= {high,low} + signed product, with 2WIDTH-bit wrap-around and no saturation.
- DIV/DIVU: low <= quotient, high <= remainder. Quotient truncates toward zero.
- Divide by zero (srcB=0, signed or unsigned):
  - low = all ones, high = srcA unmodified;
  - full latency still applies;
  - dz=1 with done.
- Signed overflow, most-negative / -1: low = most-negative value, high = 0, dz=0.
- flush=1 while busy:
  - next edge returns to IDLE, busy=0;
  - no done, HI/LO unchanged.
  - Flush has priority over COMMIT on the same edge.
- flush=1 while idle: no effect. It also blocks a start sampled on the same edge.
- reset asserted mid-operation: everything clears to the reset values; no done.
- high/low hold their old values throughout busy; there are no partial updates.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) -> busy for exactly 33 cycles; high=0xFFFFFFFE, low=0x00000001; done for one cycle; dz=0.
- MULT -3 × 5 -> high=0xFFFFFFFF, low=0xFFFFFFF1. Then MADD 2 × 3 -> high=0xFFFFFFFF, low=0xFFFFFFF7.
- DIV -7 / 2 -> low=0xFFFFFFFD, high=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> low=0x80000000, high=0.
- DIVU 0x12345678 / 0 -> after 33 cycles low=0xFFFFFFFF, high=0x12345678, dz=1 with done.
- MTHI 0xA5A5A5A5, then MULTU 3 × 4 with flush asserted in cycle 10 -> busy drops next edge, no done, high=0xA5A5A5A5 retained. Start during busy is ignored.
- DIV started, then reset pulled low in cycle 5 -> high=low=0 and busy=0 immediately, without waiting for a clock edge. After release, MTLO 7 -> low=7 in one cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with flush and MADD support.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    localparam int         CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, COMMIT} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_raw;
    logic                 is_div;
    logic                 is_madd;
    logic                 b_zero;
    logic                 neg_lo;
    logic                 neg_hi;

    logic                 signed_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [2*WIDTH-1:0]   mul_result;
    logic [WIDTH-1:0]     quo_final;
    logic [WIDTH-1:0]     rem_final;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    assign a_neg     = signed_op & srcA[WIDTH-1];
    assign b_neg     = signed_op & srcB[WIDTH-1];
    assign a_mag     = a_neg ? -srcA : srcA;
    assign b_mag     = b_neg ? -srcB : srcB;

    // During MUL the low half of acc holds the unconsumed multiplier bits.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};

    // During DIV the upper half is the partial remainder, the lower half the dividend/quotient.
    assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = rem_shift >= {1'b0, opnd};
    assign div_diff  = rem_shift - {1'b0, opnd};

    assign prod_signed = neg_lo ? -acc : acc;
    assign mul_result  = is_madd ? ({high, low} + prod_signed) : prod_signed;
    assign quo_final   = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_final   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            is_madd <= 1'b0;
            b_zero  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
            high    <= '0;
            low     <= '0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        a_raw   <= srcA;
                        b_zero  <= (srcB == '0);
                        neg_lo  <= a_neg ^ b_neg;
                        neg_hi  <= a_neg;
                        is_madd <= (op == OP_MADD);
                        cnt     <= '0;
                        case (op)
                            OP_MULT, OP_MULTU, OP_MADD: begin
                                acc    <= {{WIDTH{1'b0}}, b_mag};
                                opnd   <= a_mag;
                                is_div <= 1'b0;
                                busy   <= 1'b1;
                                state  <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                opnd   <= b_mag;
                                is_div <= 1'b1;
                                busy   <= 1'b1;
                                state  <= DIV;
                            end
                            OP_MTHI: high <= srcA;
                            OP_MTLO: low  <= srcA;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (state == MUL) begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end else if (div_ge) begin
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    // A late flush still wins, so HI/LO stay untouched.
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            {high, low} <= mul_result;
                        end else if (b_zero) begin
                            high <= a_raw;
                            low  <= '1;
                            dz   <= 1'b1;
                        end else begin
                            high <= rem_final;
                            low  <= quo_final;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_iter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             flush;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] low;

    int tests_run;
    int tests_failed;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .high  (high),
        .low   (low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result as {dz, hi, lo}, computed with plain integer arithmetic.
    function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
        logic [63:0] sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        int          q;
        int          r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd1: return {1'b0, sp};
            3'd2: return {1'b0, up};
            3'd7: return {1'b0, hilo + sp};
            3'd3: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
            3'd4: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: return {1'b0, hilo};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one start request at the current negedge; returns at the negedge after it was sampled.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic runCompute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] exp;
        int          cycles;
        exp = ref_result(o, a, b, {model_hi, model_lo});
        applyStimulus(o, a, b);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("done_while_busy", 64'(done), 64'd0);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (cycles == WIDTH / 2) begin
                checkOutput("hilo_hold", {high, low}, {model_hi, model_lo});
            end
            @(negedge clk);
        end
        checkOutput("latency", 64'(cycles), 64'(WIDTH + 1));
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("dz", 64'(dz), 64'(exp[64]));
        checkOutput("high", 64'(high), 64'(exp[63:32]));
        checkOutput("low", 64'(low), 64'(exp[31:0]));
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    task automatic applyMove(input logic [2:0] o, input logic [31:0] a);
        applyStimulus(o, a, 32'd0);
        if (o == 3'd5) model_hi = a;
        else           model_lo = a;
        checkOutput("move_busy", 64'(busy), 64'd0);
        checkOutput("move_done", 64'(done), 64'd0);
        checkOutput("move_hilo", {high, low}, {model_hi, model_lo});
    endtask

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        case ($urandom_range(0, 7))
            0:       return allow_zero ? 32'd0 : 32'd1;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] rop;
        logic [2:0] ops [5];
        tests_run    = 0;
        tests_failed = 0;
        model_hi     = '0;
        model_lo     = '0;
        ops          = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        srcA  = '0;
        srcB  = '0;
        flush = 1'b0;

        @(negedge clk);
        checkOutput("reset_high", 64'(high), 64'd0);
        checkOutput("reset_low", 64'(low), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_dz", 64'(dz), 64'd0);
        reset = 1'b1;

        // Directed corners; each op starts in the done cycle of the previous one.
        runCompute(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu_max", {high, low}, 64'hFFFF_FFFE_0000_0001);
        runCompute(3'd1, -32'd3, 32'd5);
        checkOutput("mult_neg", {high, low}, 64'hFFFF_FFFF_FFFF_FFF1);
        runCompute(3'd7, 32'd2, 32'd3);
        checkOutput("madd", {high, low}, 64'hFFFF_FFFF_FFFF_FFF7);
        runCompute(3'd3, -32'd7, 32'd2);
        checkOutput("div_neg", {high, low}, 64'hFFFF_FFFF_FFFF_FFFD);
        runCompute(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_ovf", {high, low, 31'd0, dz}, {64'h0000_0000_8000_0000, 32'd0});
        runCompute(3'd4, 32'h1234_5678, 32'd0);
        checkOutput("divu_zero", {high, low, 31'd0, dz}, {64'h1234_5678_FFFF_FFFF, 32'd1});
        runCompute(3'd3, -32'd9, 32'd0);

        for (int i = 0; i < 25; i++) begin
            rop = ops[$urandom_range(0, 4)];
            runCompute(rop, pick_operand(1'b1), pick_operand(1'b1));
        end

        // Flush mid-operation, with an ignored start while busy.
        @(negedge clk);
        applyMove(3'd5, 32'hA5A5_A5A5);
        applyMove(3'd6, 32'h0BAD_F00D);
        applyStimulus(3'd2, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 3'd6;
        srcA  = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        repeat (4) @(negedge clk);
        checkOutput("busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_done", 64'(done), 64'd0);
        checkOutput("flush_hilo", {high, low}, 64'hA5A5_A5A5_0BAD_F00D);
        @(negedge clk);
        checkOutput("flush_no_late_done", 64'(done), 64'd0);

        // Flush while idle blocks a start on the same edge.
        flush = 1'b1;
        applyStimulus(3'd5, 32'h1234_0000, 32'd0);
        flush = 1'b0;
        checkOutput("idle_flush_blocks", 64'(high), 64'hA5A5_A5A5);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(3'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_hilo", {high, low}, 64'd0);
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        checkOutput("async_rst_done", 64'(done), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyMove(3'd6, 32'd7);
        applyStimulus(3'd0, 32'h5555_5555, 32'd1);
        checkOutput("nop_ignored", {high, low, 30'd0, busy, done}, {64'h0000_0000_0000_0007, 32'd0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
